// File: rtl/hand_dealer_if.sv
// Handshake/bus bundle between the hand dealer and its controller / hand memory.
// master drives deal requests and hand_full; slave is the dealer itself.
interface hand_dealer_if;
    logic        deal_start;
    logic        new_deck;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        hand_full;
    logic        we;
    logic [2:0]  waddr;
    logic [5:0]  card_out;
    logic        busy;
    logic        deal_done;
    logic        deal_err;
    logic [5:0]  cards_left;

    modport master (
        output deal_start,
        output new_deck,
        output seed_load,
        output seed_in,
        output hand_full,
        input  we,
        input  waddr,
        input  card_out,
        input  busy,
        input  deal_done,
        input  deal_err,
        input  cards_left
    );

    modport slave (
        input  deal_start,
        input  new_deck,
        input  seed_load,
        input  seed_in,
        input  hand_full,
        output we,
        output waddr,
        output card_out,
        output busy,
        output deal_done,
        output deal_err,
        output cards_left
    );
endinterface

// File: rtl/hand_dealer.sv
// Draws unique cards from a 52-card deck with a Galois LFSR and writes
// one hand into the hand memory, then waits for the memory to report full.
module hand_dealer #(
    parameter int          HAND_SIZE    = 5,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          FULL_TIMEOUT = 16
) (
    input logic          clk,
    input logic          rst,
    hand_dealer_if.slave dif
);
    localparam int TW = $clog2(FULL_TIMEOUT) + 1;
    localparam logic [15:0] POLY = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [51:0] used_q, used_d;
    logic [5:0]  left_q, left_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        we_q, we_d;
    logic [2:0]  waddr_q, waddr_d;
    logic [5:0]  card_q, card_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [15:0] lfsr_nx;
    logic [5:0]  idx;
    logic [51:0] used_sh;
    logic        cand_ok;
    logic [1:0]  suit;
    logic [5:0]  off;
    logic [3:0]  rank;

    assign lfsr_nx = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY)
                               : (lfsr_q >> 1);

    // Candidate card from the low LFSR bits; 52..63 are rejected.
    assign idx     = lfsr_q[5:0];
    assign used_sh = used_q >> idx;
    assign cand_ok = (idx < 6'd52) && !used_sh[0];

    always_comb begin
        suit = 2'd0;
        off  = idx;
        unique case (1'b1)
            (idx >= 6'd39): begin
                suit = 2'd3;
                off  = idx - 6'd39;
            end
            (idx >= 6'd26 && idx < 6'd39): begin
                suit = 2'd2;
                off  = idx - 6'd26;
            end
            (idx >= 6'd13 && idx < 6'd26): begin
                suit = 2'd1;
                off  = idx - 6'd13;
            end
            default: begin
                suit = 2'd0;
                off  = idx;
            end
        endcase
    end

    assign rank = off[3:0] + 4'd2;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        used_d  = used_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        card_d  = card_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (dif.deal_start) begin
                    if (left_q >= 6'(HAND_SIZE)) begin
                        state_d = S_DRAW;
                        cnt_d   = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (dif.new_deck) begin
                    used_d = '0;
                    left_d = 6'd52;
                end else if (dif.seed_load) begin
                    lfsr_d = (dif.seed_in == 16'd0) ? LFSR_SEED
                                                    : dif.seed_in;
                end
            end
            S_DRAW: begin
                lfsr_d = lfsr_nx;
                if (cand_ok) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    card_d  = {suit, rank};
                    used_d  = used_q | (52'd1 << idx);
                    left_d  = left_q - 6'd1;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'(HAND_SIZE - 1)) begin
                        state_d = S_WAIT;
                        timer_d = '0;
                    end
                end
            end
            S_WAIT: begin
                if (dif.hand_full) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (timer_q == TW'(FULL_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            used_q  <= '0;
            left_q  <= 6'd52;
            cnt_q   <= 3'd0;
            timer_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= 3'd0;
            card_q  <= 6'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            used_q  <= used_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            card_q  <= card_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign dif.we         = we_q;
    assign dif.waddr      = waddr_q;
    assign dif.card_out   = card_q;
    assign dif.busy       = busy_q;
    assign dif.deal_done  = done_q;
    assign dif.deal_err   = err_q;
    assign dif.cards_left = left_q;
endmodule
